// File: rtl/div_cfg_ctrl.sv
// Configuration sequencer for a counter-based clock divider. Ratio changes and stops
// are applied only on the falling edge of clk_div, so no runt phase is ever produced.
module div_cfg_ctrl #(
  parameter int unsigned CW = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          cfg_valid_i,
  output logic          cfg_ready_o,
  input  logic          cfg_enable_i,
  input  logic [CW-1:0] cfg_half_i,
  output logic          clk_div_o,
  output logic          div_active_o,
  output logic          rise_pulse_o,
  output logic          fall_pulse_o,
  output logic          cfg_err_o
);

  typedef enum logic [1:0] {StIdle, StRun, StPend} state_e;

  localparam logic [CW-1:0] CntOne = CW'(1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] half_q, half_d;
  logic [CW-1:0] sh_half_q, sh_half_d;
  logic          sh_en_q, sh_en_d;
  logic          clk_div_q, clk_div_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic          err_q, err_d;

  logic accept, illegal, toggle;

  assign cfg_ready_o  = rst_ni && (state_q != StPend);
  assign div_active_o = (state_q != StIdle);
  assign clk_div_o    = clk_div_q;
  assign rise_pulse_o = rise_q;
  assign fall_pulse_o = fall_q;
  assign cfg_err_o    = err_q;

  assign accept  = cfg_valid_i && cfg_ready_o;
  assign illegal = accept && cfg_enable_i && (cfg_half_i == '0);
  // half_q is never zero while counting, so H-1 cannot underflow.
  assign toggle  = (cnt_q == half_q - CntOne);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    half_d    = half_q;
    sh_half_d = sh_half_q;
    sh_en_d   = sh_en_q;
    clk_div_d = clk_div_q;
    rise_d    = 1'b0;
    fall_d    = 1'b0;
    err_d     = illegal;

    unique case (state_q)
      StIdle: begin
        cnt_d     = '0;
        clk_div_d = 1'b0;
        if (accept && cfg_enable_i && !illegal) begin
          half_d  = cfg_half_i;
          state_d = StRun;
        end
      end
      StRun, StPend: begin
        if (toggle) begin
          cnt_d     = '0;
          clk_div_d = ~clk_div_q;
          rise_d    = ~clk_div_q;
          fall_d    = clk_div_q;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
        if (state_q == StRun) begin
          if (accept && !illegal) begin
            sh_en_d   = cfg_enable_i;
            sh_half_d = cfg_half_i;
            state_d   = StPend;
          end
        end else if (toggle && clk_div_q) begin
          // Falling toggle: the shadow takes effect at the start of a fresh low phase.
          if (sh_en_q) begin
            half_d  = sh_half_q;
            state_d = StRun;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      half_q    <= '0;
      sh_half_q <= '0;
      sh_en_q   <= 1'b0;
      clk_div_q <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      half_q    <= half_d;
      sh_half_q <= sh_half_d;
      sh_en_q   <= sh_en_d;
      clk_div_q <= clk_div_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      err_q     <= err_d;
    end
  end

endmodule
